nx_msg_arbiter: RTL and testbench
=================================

// Module: nx_msg_arbiter
// PURPOSE
// - Shares one outbound Nexus message channel (e.g. the host-bound side of an
//   nx_axi4s_bridge) between REQUESTERS message sources.
// - Intended use: merge the ctrl and mesh outbound streams of a nexus core onto
//   a single bridge.
// - Round-robin arbitration with per-grant bursting up to MAX_BURST messages.
// - Registered output stage with a tag identifying the source of each message.
// PARAMETERS
// - REQUESTERS   2    number of requesting message streams (>=2)
// - DATA_WIDTH   31   width of one Nexus message
// - MAX_BURST    8    max messages accepted per grant before re-arbitration (>=1)
// - localparam SRC_WIDTH = $clog2(REQUESTERS); localparam CNT_WIDTH = $clog2(MAX_BURST+1)
// PORTS
// - clk_i         in   1                      clock
// - rstn_i        in   1                      asynchronous active-low reset
// - req_data_i    in   REQUESTERS*DATA_WIDTH  message from requester r at [r*DATA_WIDTH +: DATA_WIDTH]
// - req_valid_i   in   REQUESTERS             requester r has a message
// - req_ready_o   out  REQUESTERS             message from requester r accepted this cycle
// - arb_data_o    out  DATA_WIDTH             arbitrated message
// - arb_source_o  out  SRC_WIDTH              index of requester that produced arb_data_o
// - arb_valid_o   out  1                      arb_data_o/arb_source_o valid
// - arb_ready_i   in   1                      downstream accepts arb_data_o
// - grant_o       out  REQUESTERS             one-hot current grant, 0 when idle
// BEHAVIOUR
// - Single clock domain: clk_i.
// - Reset: rstn_i is asynchronous assert, synchronous deassert by the system.
//   - All flops clear: arb_valid_o=0, arb_data_o=0, arb_source_o=0, grant_o=0,
//     req_ready_o=0, state=IDLE, burst count=0, rr pointer=0.
//   - Reset mid-transfer drops any held message; no message is replayed.
// - Handshake: a transfer occurs on the rising edge where valid & ready are both high.
//   - req_valid_i must not depend on req_ready_o.
//   - Output stays stable while arb_valid_o=1 and arb_ready_i=0.
// - Output stage is a single register. out_free = ~arb_valid_o | arb_ready_i.
// - req_ready_o[r] = grant_o[r] & out_free (combinational); all other bits are 0.
// - Latency: a message accepted in cycle N appears on arb_data_o in cycle N+1.
//   - Full throughput: 1 msg/cycle while a grant holds and arb_ready_i=1.
// - FSM:
//   - IDLE:
//     - Searches for a valid requester starting at the rr pointer, wrapping
//       modulo REQUESTERS.
//     - If one is found, in the next cycle: grant_o = onehot(winner), count=0,
//       state=GRANT.
//     - Costs 1 bubble cycle per grant.
//   - GRANT:
//     - Each accept increments count.
//     - Release to IDLE on the first of:
//       (a) accept with count==MAX_BURST-1 (burst exhausted), or
//       (b) req_valid_i[granted]==0 in any cycle.
//     - A stall (out_free=0) holds the grant and does not count.
//     - On release: grant_o=0; rr pointer = granted+1, wrapping REQUESTERS-1 -> 0.
// - Fairness: no requester waits more than (REQUESTERS-1)*MAX_BURST accepts by others.
// - Simultaneous events:
//   - Downstream pop and accept in the same cycle: the register is refilled,
//     arb_valid_o stays 1.
//   - Burst exhausted and valid drop in the same cycle: a single release;
//     the pointer advances once.
// - arb_valid_o clears only when arb_ready_i=1 and there is no accept that cycle.
// TESTING
// - Reset: hold rstn_i=0 with all req_valid_i=1 -> all outputs 0;
//   assert rstn_i low mid-burst -> arb_valid_o=0 within the same cycle.
// - Single requester: req 1 streams 0x1..0x5 with arb_ready_i=1 ->
//   - arb_data_o = 0x1..0x5 in order, arb_source_o=1, 1 cycle latency;
//   - one bubble after grant.
// - Round-robin burst: both requesters always valid, MAX_BURST=8, 32 msgs each ->
//   - output alternates in runs of 8: src0 x8, src1 x8, ...
//   - no message is lost or duplicated.
// - Backpressure: arb_ready_i toggles 1/0 every cycle during a burst ->
//   - arb_data_o holds stable while stalled;
//   - burst count advances only on accepts; 8 msgs still complete the burst.
// - Early release: req 0 drops valid after 3 msgs with req 1 pending ->
//   - grant moves to req 1 after one IDLE cycle;
//   - after req 1 releases, req 0 is granted next.
// - Pointer wrap: REQUESTERS=3, only req 2 then req 0 valid ->
//   - pointer wraps 2 -> 0; req 0 is served after req 2 with no starvation.

Source files
------------

// File: rtl/nx_msg_arbiter.sv
// Round-robin arbiter that merges REQUESTERS message streams onto one channel,
// granting bursts of up to MAX_BURST messages into a single registered output stage.
module nx_msg_arbiter #(
    parameter int REQUESTERS = 2,
    parameter int DATA_WIDTH = 31,
    parameter int MAX_BURST  = 8,
    localparam int SRC_WIDTH = $clog2(REQUESTERS),
    localparam int CNT_WIDTH = $clog2(MAX_BURST + 1)
) (
    input  logic                             clk_i,
    input  logic                             rstn_i,
    input  logic [REQUESTERS*DATA_WIDTH-1:0] req_data_i,
    input  logic [REQUESTERS-1:0]            req_valid_i,
    output logic [REQUESTERS-1:0]            req_ready_o,
    output logic [DATA_WIDTH-1:0]            arb_data_o,
    output logic [SRC_WIDTH-1:0]             arb_source_o,
    output logic                             arb_valid_o,
    input  logic                             arb_ready_i,
    output logic [REQUESTERS-1:0]            grant_o
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                  r_state;
    logic [REQUESTERS-1:0]   r_grant;
    logic [SRC_WIDTH-1:0]    r_gidx;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic [SRC_WIDTH-1:0]    r_ptr;
    logic                    r_valid;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [SRC_WIDTH-1:0]    r_src;

    state_t                  w_state_nxt;
    logic [REQUESTERS-1:0]   w_grant_nxt;
    logic [SRC_WIDTH-1:0]    w_gidx_nxt;
    logic [CNT_WIDTH-1:0]    w_cnt_nxt;
    logic [SRC_WIDTH-1:0]    w_ptr_nxt;
    logic                    w_out_free;
    logic                    w_accept;
    logic                    w_found;
    logic [SRC_WIDTH-1:0]    w_win;
    logic [SRC_WIDTH-1:0]    w_ptr_inc;
    logic [DATA_WIDTH-1:0]   w_sel_data;

    assign w_out_free   = ~r_valid | arb_ready_i;
    assign w_accept     = (r_state == ST_GRANT) & req_valid_i[r_gidx] & w_out_free;
    assign w_sel_data   = req_data_i[r_gidx*DATA_WIDTH +: DATA_WIDTH];
    assign w_ptr_inc    = (r_gidx == SRC_WIDTH'(REQUESTERS - 1)) ? '0 : r_gidx + 1'b1;

    assign req_ready_o  = r_grant & {REQUESTERS{w_out_free}};
    assign grant_o      = r_grant;
    assign arb_valid_o  = r_valid;
    assign arb_data_o   = r_data;
    assign arb_source_o = r_src;

    // First valid requester at or after the rr pointer, wrapping modulo REQUESTERS.
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_found = 1'b0;
        w_win   = '0;
        idx     = 0;
        for (int i = 0; i < REQUESTERS; i++) begin
            idx = int'(r_ptr) + i;
            if (idx >= REQUESTERS) idx = idx - REQUESTERS;
            if (!w_found && req_valid_i[idx]) begin
                w_found = 1'b1;
                w_win   = SRC_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_gidx_nxt  = r_gidx;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_grant_nxt = REQUESTERS'(1) << w_win;
                    w_gidx_nxt  = w_win;
                    w_cnt_nxt   = '0;
                end
            end
            ST_GRANT: begin
                if (!req_valid_i[r_gidx] ||
                    (w_accept && r_cnt == CNT_WIDTH'(MAX_BURST - 1))) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_ptr_nxt   = w_ptr_inc;
                end else if (w_accept) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_cnt   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_gidx  <= w_gidx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // A pop and a refill in the same cycle keep the register valid.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_src   <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= w_sel_data;
            r_src   <= r_gidx;
        end else if (arb_ready_i) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nx_msg_arbiter.sv
// Randomized bench for nx_msg_arbiter: transaction-level round-robin model plus
// per-scenario stream checks on a 2-requester and a 3-requester instance.
module tb_nx_msg_arbiter;

    localparam int DW = 31;
    localparam int MB = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      v2, rdy2_o, g2;
    logic [2*DW-1:0] dat2;
    logic [DW-1:0]   a2_d;
    logic            a2_s, a2_v, r2;

    logic [2:0]      v3, rdy3_o, g3;
    logic [3*DW-1:0] dat3;
    logic [DW-1:0]   a3_d;
    logic [1:0]      a3_s;
    logic            a3_v, r3;

    nx_msg_arbiter #(.REQUESTERS(2), .DATA_WIDTH(DW), .MAX_BURST(MB)) u_dut2 (
        .clk_i(clk), .rstn_i(rstn), .req_data_i(dat2), .req_valid_i(v2),
        .req_ready_o(rdy2_o), .arb_data_o(a2_d), .arb_source_o(a2_s),
        .arb_valid_o(a2_v), .arb_ready_i(r2), .grant_o(g2));

    nx_msg_arbiter #(.REQUESTERS(3), .DATA_WIDTH(DW), .MAX_BURST(MB)) u_dut3 (
        .clk_i(clk), .rstn_i(rstn), .req_data_i(dat3), .req_valid_i(v3),
        .req_ready_o(rdy3_o), .arb_data_o(a3_d), .arb_source_o(a3_s),
        .arb_valid_o(a3_v), .arb_ready_i(r3), .grant_o(g3));

    int total = 0;
    int bad   = 0;

    // Stimulus: each source emits base+1, base+2, ... while it has messages left.
    int          n = 2;
    int          rem[3];
    int          seq[3];
    int          pv[3];
    logic [DW-1:0] base[3];
    int          rmode;
    bit          vld[3];
    bit          rdy;
    int          cyc;

    // Reference: granted source (-1 = idle), burst count, rr pointer, output register.
    int            m_gnt, m_cnt, m_ptr, m_src;
    bit            m_valid;
    logic [DW-1:0] m_data;

    typedef struct {
        int            src;
        logic [DW-1:0] data;
        int            cyc;
    } rx_t;
    rx_t rx[$];

    function automatic logic [DW-1:0] dat(int r);
        return base[r] + DW'(seq[r]);
    endfunction

    task automatic model_reset();
        m_gnt = -1; m_cnt = 0; m_ptr = 0; m_src = 0; m_valid = 0; m_data = '0;
    endtask

    task automatic model_edge();
        bit ofree = !m_valid || rdy;
        bit acc   = 0;
        if (m_gnt < 0) begin
            for (int i = 0; i < n; i++) begin
                int r = (m_ptr + i) % n;
                if (vld[r]) begin
                    m_gnt = r; m_cnt = 0;
                    break;
                end
            end
        end else if (!vld[m_gnt]) begin
            m_ptr = (m_gnt + 1) % n; m_gnt = -1;
        end else if (ofree) begin
            acc    = 1;
            m_data = dat(m_gnt);
            m_src  = m_gnt;
            seq[m_gnt]++;
            rem[m_gnt]--;
            m_cnt++;
            if (m_cnt == MB) begin
                m_ptr = (m_gnt + 1) % n; m_gnt = -1;
            end
        end
        if (acc) m_valid = 1;
        else if (rdy) m_valid = 0;
    endtask

    task automatic drive();
        for (int r = 0; r < 3; r++)
            vld[r] = (r < n) && (rem[r] > 0) && ($urandom_range(99) < pv[r]);
        case (rmode)
            0:       rdy = 1;
            1:       rdy = (cyc % 2) == 0;
            default: rdy = $urandom_range(99) < 70;
        endcase
        v2   = (n == 2) ? {vld[1], vld[0]} : 2'b00;
        dat2 = {dat(1), dat(0)};
        r2   = (n == 2) ? rdy : 1'b1;
        v3   = (n == 3) ? {vld[2], vld[1], vld[0]} : 3'b000;
        dat3 = {dat(2), dat(1), dat(0)};
        r3   = (n == 3) ? rdy : 1'b1;
    endtask

    task automatic cycle();
        logic [2:0]    o_g, o_rdy, e_g, e_rdy;
        logic [DW-1:0] o_d;
        int            o_s;
        bit            o_v;
        drive();
        @(negedge clk);
        o_g   = (n == 3) ? g3 : {1'b0, g2};
        o_rdy = (n == 3) ? rdy3_o : {1'b0, rdy2_o};
        o_d   = (n == 3) ? a3_d : a2_d;
        o_s   = (n == 3) ? int'(a3_s) : int'(a2_s);
        o_v   = (n == 3) ? a3_v : a2_v;
        e_g   = (m_gnt < 0) ? 3'b000 : (3'b001 << m_gnt);
        e_rdy = (!m_valid || rdy) ? e_g : 3'b000;
        total++;
        if (o_g !== e_g) begin
            bad++; $display("FAIL grant cyc=%0d got=%b exp=%b", cyc, o_g, e_g);
        end
        total++;
        if (o_rdy !== e_rdy) begin
            bad++; $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, o_rdy, e_rdy);
        end
        total++;
        if (o_v !== m_valid) begin
            bad++; $display("FAIL arb_valid cyc=%0d got=%b exp=%b", cyc, o_v, m_valid);
        end
        if (m_valid) begin
            total++;
            if (o_d !== m_data || o_s != m_src) begin
                bad++;
                $display("FAIL arb_out cyc=%0d got=%h/%0d exp=%h/%0d", cyc, o_d, o_s, m_data, m_src);
            end
        end
        if (o_v && rdy) rx.push_back('{o_s, o_d, cyc});
        model_edge();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(int cycles);
        for (int i = 0; i < cycles; i++) cycle();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic setup(int nn, int rm, int p0, int p1, int p2, int q0, int q1, int q2,
                         logic [DW-1:0] b1, logic [DW-1:0] b2);
        n = nn; rmode = rm; cyc = 0;
        pv[0] = p0; pv[1] = p1; pv[2] = p2;
        rem[0] = q0; rem[1] = q1; rem[2] = q2;
        base[0] = '0; base[1] = b1; base[2] = b2;
        for (int r = 0; r < 3; r++) seq[r] = 1;
        rx.delete();
        v2 = '0; v3 = '0; r2 = 1'b1; r3 = 1'b1;
        do_reset();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        v2 = 2'b11; v3 = 3'b111; r2 = 1'b1; r3 = 1'b1;
        dat2 = {2*DW{1'b1}}; dat3 = {3*DW{1'b1}};
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (a2_v !== 1'b0)   begin bad++; $display("FAIL rst_valid2 got=%b exp=0", a2_v); end
        total++; if (a2_d !== '0)     begin bad++; $display("FAIL rst_data2 got=%h exp=0", a2_d); end
        total++; if (a2_s !== 1'b0)   begin bad++; $display("FAIL rst_src2 got=%b exp=0", a2_s); end
        total++; if (g2 !== 2'b00)    begin bad++; $display("FAIL rst_grant2 got=%b exp=0", g2); end
        total++; if (rdy2_o !== 2'b00) begin bad++; $display("FAIL rst_ready2 got=%b exp=0", rdy2_o); end
        total++; if (a3_v !== 1'b0)   begin bad++; $display("FAIL rst_valid3 got=%b exp=0", a3_v); end
        total++; if (a3_d !== '0)     begin bad++; $display("FAIL rst_data3 got=%h exp=0", a3_d); end
        total++; if (a3_s !== 2'b00)  begin bad++; $display("FAIL rst_src3 got=%b exp=0", a3_s); end
        total++; if (g3 !== 3'b000)   begin bad++; $display("FAIL rst_grant3 got=%b exp=0", g3); end
        total++; if (rdy3_o !== 3'b000) begin bad++; $display("FAIL rst_ready3 got=%b exp=0", rdy3_o); end

        // Reset asserted in the middle of a burst clears the output at once.
        setup(2, 0, 100, 100, 0, 20, 20, 0, DW'(1) << 24, '0);
        run(5);
        #2;
        rstn = 1'b0;
        #1;
        total++; if (a2_v !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", a2_v); end
        total++; if (g2 !== 2'b00)  begin bad++; $display("FAIL midrst_grant got=%b exp=0", g2); end
        total++; if (a2_d !== '0)   begin bad++; $display("FAIL midrst_data got=%h exp=0", a2_d); end
        v2 = '0;
        do_reset();
    endtask

    task automatic test_single();
        setup(2, 0, 0, 100, 0, 0, 5, 0, '0, '0);
        run(10);
        total++;
        if (rx.size() != 5) begin
            bad++; $display("FAIL single_count got=%0d exp=5", rx.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (rx[i].data !== DW'(i + 1) || rx[i].src != 1) begin
                    bad++;
                    $display("FAIL single_msg%0d got=%h/%0d exp=%h/1", i, rx[i].data, rx[i].src, i + 1);
                end
            end
            // Cycle 0 is the arbitration bubble, cycle 1 the first accept.
            total++;
            if (rx[0].cyc != 2) begin
                bad++; $display("FAIL single_latency got=%0d exp=2", rx[0].cyc);
            end
        end
    endtask

    task automatic test_round_robin();
        setup(2, 0, 100, 100, 0, 32, 32, 0, DW'(1) << 24, '0);
        run(100);
        total++;
        if (rx.size() != 64) begin
            bad++; $display("FAIL rr_count got=%0d exp=64", rx.size());
        end else begin
            for (int i = 0; i < 64; i++) begin
                int            es = (i / 8) % 2;
                logic [DW-1:0] ed = base[es] + DW'((i / 16) * 8 + (i % 8) + 1);
                total++;
                if (rx[i].src != es || rx[i].data !== ed) begin
                    bad++;
                    $display("FAIL rr_msg%0d got=%h/%0d exp=%h/%0d", i, rx[i].data, rx[i].src, ed, es);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        setup(2, 1, 100, 100, 0, 12, 4, 0, DW'(1) << 24, '0);
        run(60);
        total++;
        if (rx.size() != 16) begin
            bad++; $display("FAIL bp_count got=%0d exp=16", rx.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                int es = (i >= 8 && i < 12) ? 1 : 0;
                total++;
                if (rx[i].src != es) begin
                    bad++; $display("FAIL bp_src%0d got=%0d exp=%0d", i, rx[i].src, es);
                end
            end
        end
    endtask

    task automatic test_early_release();
        int exp_src[10] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0};
        setup(2, 0, 100, 100, 0, 3, 4, 0, DW'(1) << 24, '0);
        run(8);
        rem[0] = rem[0] + 3;
        run(30);
        total++;
        if (rx.size() != 10) begin
            bad++; $display("FAIL early_count got=%0d exp=10", rx.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                total++;
                if (rx[i].src != exp_src[i]) begin
                    bad++; $display("FAIL early_src%0d got=%0d exp=%0d", i, rx[i].src, exp_src[i]);
                end
            end
        end
    endtask

    task automatic test_pointer_wrap();
        int exp_src[6] = '{2, 2, 2, 0, 0, 0};
        setup(3, 0, 100, 100, 100, 0, 0, 3, DW'(1) << 24, DW'(2) << 24);
        run(2);
        rem[0] = 3;
        run(20);
        total++;
        if (rx.size() != 6) begin
            bad++; $display("FAIL wrap_count got=%0d exp=6", rx.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (rx[i].src != exp_src[i]) begin
                    bad++; $display("FAIL wrap_src%0d got=%0d exp=%0d", i, rx[i].src, exp_src[i]);
                end
            end
        end
    endtask

    task automatic test_random(int nn, int cycles);
        setup(nn, 2, 70, 60, 80, 400, 400, 400, DW'(1) << 24, DW'(2) << 24);
        run(cycles);
        rmode = 0;
        for (int r = 0; r < 3; r++) rem[r] = 0;
        run(5);
        // Per source, messages arrive once each and in order.
        for (int r = 0; r < nn; r++) begin
            int k = 1;
            foreach (rx[i]) begin
                if (rx[i].src == r) begin
                    total++;
                    if (rx[i].data !== base[r] + DW'(k)) begin
                        bad++;
                        $display("FAIL rand%0d_order src=%0d got=%h exp=%h", nn, r, rx[i].data, base[r] + DW'(k));
                    end
                    k++;
                end
            end
            total++;
            if (k != seq[r]) begin
                bad++; $display("FAIL rand%0d_conserve src=%0d got=%0d exp=%0d", nn, r, k - 1, seq[r] - 1);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_early_release();
        test_pointer_wrap();
        test_random(2, 600);
        test_random(3, 600);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
